// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud divider computation reused by the transmitter. UART_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;
`endif

  // Rounded clocks-per-tick; never below 1 so the tick always exists.
  function automatic int uart_div(input int clk_hz, input int baud, input int oversample);
    int denom;
    int div;
    denom = baud * oversample;
    div   = (clk_hz + denom / 2) / denom;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, restartable
// through a synchronous clear so sampling phase aligns to the start edge.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding buffer and framing/overrun
// reporting. Defining UART_PARITY_EN adds a parity bit, PARITY_ODD and io_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_rx,
  output logic [DATA_BITS-1:0] io_data,
  output logic                 io_valid,
  input  logic                 io_ready,
  output logic                 io_frame_err,
  output logic                 io_overrun
`ifdef UART_PARITY_EN
  ,
  output logic                 io_parity_err
`endif
);

  localparam int DIV  = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_meta, rx_sync, rx_prev;
  logic tick, div_clear;

  rx_state_t state, state_nxt;
  logic [OS_W-1:0]      os_cnt, os_cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 byte_done, frame_bad;
`ifdef UART_PARITY_EN
  logic                 par_q, par_nxt, parity_bad;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clock),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    div_clear   = 1'b0;
`ifdef UART_PARITY_EN
    par_nxt     = par_q;
    parity_bad  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // Divider held cleared so START counts from the detected edge.
        div_clear   = 1'b1;
        os_cnt_nxt  = '0;
        bit_idx_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = ST_START;
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt == HALF_LAST) begin
            os_cnt_nxt = '0;
            state_nxt  = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt_nxt = os_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_cnt_nxt  = '0;
            shift_nxt   = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_idx_nxt = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
              state_nxt = ST_PARITY;
`else
              state_nxt = ST_STOP;
`endif
            end
          end else begin
            os_cnt_nxt = os_cnt + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_cnt_nxt = '0;
            par_nxt    = rx_sync;
            state_nxt  = ST_STOP;
          end else begin
            os_cnt_nxt = os_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            // Back to IDLE at mid-stop-bit to leave resync margin.
            os_cnt_nxt = '0;
            state_nxt  = ST_IDLE;
            frame_bad  = !rx_sync;
`ifdef UART_PARITY_EN
            parity_bad = (par_q != ((^shift_q) ^ PARITY_ODD));
            byte_done  = rx_sync && !parity_bad;
`else
            byte_done  = rx_sync;
`endif
          end else begin
            os_cnt_nxt = os_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= ST_IDLE;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shift_q      <= '0;
      io_data      <= '0;
      io_valid     <= 1'b0;
      io_frame_err <= 1'b0;
      io_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q         <= 1'b0;
      io_parity_err <= 1'b0;
`endif
    end else begin
      rx_meta      <= io_rx;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      state        <= state_nxt;
      os_cnt       <= os_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift_q      <= shift_nxt;
      io_frame_err <= frame_bad;
      io_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q         <= par_nxt;
      io_parity_err <= parity_bad;
`endif
      // A same-cycle pop frees the slot, so the new byte replaces it.
      if (byte_done) begin
        if (!io_valid || io_ready) begin
          io_data  <= shift_q;
          io_valid <= 1'b1;
        end else begin
          io_overrun <= 1'b1;
        end
      end else if (io_valid && io_ready) begin
        io_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clocks per bit; received bytes are
// checked against a queue of expected bytes filled as frames are sent.
module tb_uart_rx;

  localparam int BIT_CLKS = 160;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_rx;
  logic [7:0] io_data;
  logic       io_valid;
  logic       io_ready;
  logic       io_frame_err;
  logic       io_overrun;
`ifdef UART_PARITY_EN
  logic       io_parity_err;
  bit         bad_parity = 1'b0;
  int         parity_pulses = 0;
  int         p0;
`endif

  int tests = 0;
  int fails = 0;
  int valid_hi = 0;
  int frame_pulses = 0;
  int overrun_pulses = 0;
  int pops = 0;
  int v0, f0, o0, n0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  uart_rx #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD_RATE   (10_000),
    .OVERSAMPLE  (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx        (io_rx),
    .io_data      (io_data),
    .io_valid     (io_valid),
    .io_ready     (io_ready),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun)
`ifdef UART_PARITY_EN
    ,
    .io_parity_err(io_parity_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    io_rx = 1'b0;
    waitClocks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      io_rx = data[i];
      waitClocks(BIT_CLKS);
    end
`ifdef UART_PARITY_EN
    io_rx = (^data) ^ bad_parity;
    waitClocks(BIT_CLKS);
`endif
    io_rx = stop_bit;
    waitClocks(BIT_CLKS);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (io_valid) valid_hi++;
      if (io_frame_err) frame_pulses++;
      if (io_overrun) overrun_pulses++;
`ifdef UART_PARITY_EN
      if (io_parity_err) parity_pulses++;
`endif
      if (io_valid && io_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("[TB] FAIL sb_unexpected: observed byte %02h expected none", io_data);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("sb_data", {24'd0, io_data}, {24'd0, exp_byte});
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    io_rx    = 1'b1;
    io_ready = 1'b1;
    waitClocks(5);
    checkOutput("rst_data", {24'd0, io_data}, 32'h0);
    checkOutput("rst_valid", {31'd0, io_valid}, 32'h0);
    checkOutput("rst_frame", {31'd0, io_frame_err}, 32'h0);
    checkOutput("rst_overrun", {31'd0, io_overrun}, 32'h0);
`ifdef UART_PARITY_EN
    checkOutput("rst_parity", {31'd0, io_parity_err}, 32'h0);
`endif
    reset = 1'b0;
    waitClocks(50);

    // Single byte, consumer always ready
    v0 = valid_hi; f0 = frame_pulses; o0 = overrun_pulses; n0 = pops;
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1);
    waitClocks(200);
    checkOutput("a5_pops", pops - n0, 1);
    checkOutput("a5_valid_cycles", valid_hi - v0, 1);
    checkOutput("a5_frame", frame_pulses - f0, 0);
    checkOutput("a5_overrun", overrun_pulses - o0, 0);

    // Short glitch must be rejected as a false start
    v0 = valid_hi; f0 = frame_pulses; n0 = pops;
    io_rx = 1'b0;
    waitClocks(60);
    io_rx = 1'b1;
    waitClocks(300);
    checkOutput("glitch_valid", valid_hi - v0, 0);
    checkOutput("glitch_frame", frame_pulses - f0, 0);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1);
    waitClocks(200);
    checkOutput("glitch_next_pops", pops - n0, 1);

    // Framing error followed by a held-low line, then a good byte
    f0 = frame_pulses; n0 = pops;
    applyStimulus(8'h3C, 1'b0);
    waitClocks(2000);
    io_rx = 1'b1;
    waitClocks(300);
    checkOutput("ferr_pulses", frame_pulses - f0, 1);
    checkOutput("ferr_no_byte", pops - n0, 0);
    exp_q.push_back(8'h55);
    applyStimulus(8'h55, 1'b1);
    waitClocks(200);
    checkOutput("ferr_next_pops", pops - n0, 1);
    checkOutput("ferr_total_pulses", frame_pulses - f0, 1);

    // Overrun: second byte dropped while the first is held
    io_ready = 1'b0;
    o0 = overrun_pulses; n0 = pops;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1);
    waitClocks(100);
    applyStimulus(8'h22, 1'b1);
    waitClocks(200);
    checkOutput("ovr_valid", {31'd0, io_valid}, 32'h1);
    checkOutput("ovr_data", {24'd0, io_data}, 32'h11);
    checkOutput("ovr_pulses", overrun_pulses - o0, 1);
    io_ready = 1'b1;
    waitClocks(2);
    checkOutput("ovr_pop_valid", {31'd0, io_valid}, 32'h0);
    checkOutput("ovr_pops", pops - n0, 1);

    // Back-to-back frames with no idle gap
    n0 = pops; f0 = frame_pulses;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    waitClocks(200);
    checkOutput("b2b_pops", pops - n0, 2);
    checkOutput("b2b_frame", frame_pulses - f0, 0);

    // Reset in the middle of a third frame
    io_rx = 1'b0;
    waitClocks(500);
    reset = 1'b1;
    io_rx = 1'b1;
    waitClocks(3);
    checkOutput("mid_rst_data", {24'd0, io_data}, 32'h0);
    checkOutput("mid_rst_valid", {31'd0, io_valid}, 32'h0);
    checkOutput("mid_rst_frame", {31'd0, io_frame_err}, 32'h0);
    checkOutput("mid_rst_overrun", {31'd0, io_overrun}, 32'h0);
    reset = 1'b0;
    v0 = valid_hi; f0 = frame_pulses; o0 = overrun_pulses;
    waitClocks(2000);
    checkOutput("post_rst_valid", valid_hi - v0, 0);
    checkOutput("post_rst_frame", frame_pulses - f0, 0);
    checkOutput("post_rst_overrun", overrun_pulses - o0, 0);

`ifdef UART_PARITY_EN
    // Wrong parity bit drops the byte, correct one delivers it
    p0 = parity_pulses; n0 = pops;
    bad_parity = 1'b1;
    applyStimulus(8'h07, 1'b1);
    waitClocks(200);
    checkOutput("par_err_pulses", parity_pulses - p0, 1);
    checkOutput("par_err_no_byte", pops - n0, 0);
    bad_parity = 1'b0;
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1);
    waitClocks(200);
    checkOutput("par_ok_pops", pops - n0, 1);
    checkOutput("par_ok_pulses", parity_pulses - p0, 1);
`endif

    checkOutput("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
